codec_cfg_sched: RTL and testbench
==================================

# codec_cfg_sched

Configuration scheduler for the audio codec's I2C control port. After reset it replays the 10-word codec boot table. It then shares the single I2C frame writer between two runtime requesters (A: user controls, B: record path) with round-robin arbitration. NACKed frames are retried a bounded number of times. The block sits between the control logic and the I2C frame writer that serialises 24-bit frames onto I2C_SCLK/I2C_SDAT.

## Interface
- DEV_ADDR, 8'h34, device address byte (write) placed in frame bits [23:16]
- MAX_RETRY, 3, re-issues allowed per frame after a NACK (total attempts = MAX_RETRY+1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  write request; level, held until gnt
- addr_a / addr_b  in  7  codec register address
- data_a / data_b  in  9  codec register data
- gnt_a / gnt_b  out  1  one-cycle pulse: request accepted, addr/data captured
- frm_start  out  1  one-cycle pulse: start a frame
- frm_data  out  24  {DEV_ADDR, addr[6:0], data[8:0]}
- frm_busy  in  1  writer busy
- frm_done  in  1  one-cycle pulse: frame finished
- frm_nack  in  1  valid with frm_done; 1 = slave did not acknowledge
- boot_done  out  1  boot table finished; stays high until reset
- busy  out  1  high in any state except S_IDLE
- err  out  1  sticky: some frame was dropped after exhausting retries

## Operation
- All outputs are registered. Reset values are 0 for every output, including frm_data.
- States:
  - S_BOOT_ISSUE: boot_idx 0..9, build the frame from the boot table.
  - S_BOOT_WAIT
  - S_IDLE
  - S_ISSUE
  - S_WAIT
- Boot table (addr:data):
  - 0:097, 1:097, 2:079, 3:079, 4:015
  - 5:000, 6:000, 7:042, 8:019, 9:001
- In *_ISSUE states:
  - frm_start pulses in the first cycle that frm_busy = 0; until then the block holds.
  - The next state is the matching *_WAIT.
- In *_WAIT, on frm_done:
  - nack = 0: the frame succeeded.
  - nack = 1 and retry_cnt < MAX_RETRY: increment retry_cnt and return to *_ISSUE with the same frm_data.
  - nack = 1 and retry_cnt = MAX_RETRY: set err and drop the frame. The block advances as if the frame succeeded.
  - retry_cnt clears on every frame advance.
- Boot advance:
  - Advance means boot_idx+1 and back to S_BOOT_ISSUE.
  - After index 9, set boot_done and go to S_IDLE.
  - A dropped boot frame does not abort boot.
- Requests are ignored while boot_done = 0.
- In S_IDLE, arbitration:
  - Only one requester high: grant it.
  - Both high: grant the one not granted last. The last-grant pointer resets to B, so A wins the first tie.
  - On grant: capture addr/data into frm_data, pulse gnt_x, go to S_ISSUE.
  - The requester may drop or change req/addr/data after gnt.
- Frame done, runtime path: return to S_IDLE.
- frm_done outside *_WAIT is ignored. frm_nack without frm_done is ignored.
- Reset mid-operation clears everything, including boot_done, err, pointer and boot_idx. Boot restarts from index 0.

## Timing
- Reset release: frm_start high in the 1st cycle after release (frm_busy = 0), with frm_data = 24'h340097.
- Grant latency: req sampled high in S_IDLE at edge k → gnt_x and the S_ISSUE entry at k+1 → frm_start at k+2 if frm_busy = 0.
- frm_data is stable from the frm_start cycle through frm_done.
- frm_done at edge k in S_WAIT:
  - Success: S_IDLE at k+1, so the next grant is possible at k+2.
  - Retry: frm_start at k+2 (frm_busy = 0).
- frm_start is never asserted while frm_busy = 1.
- At most one frm_start per attempt.
- gnt_a and gnt_b are never high together.

## Structure
- Package codec_cfg_pkg holds:
  - the state enum
  - the 10-entry boot table constants, N_BOOT = 10
  - the frame-build function {dev, addr, data}
- Sub-module codec_boot_rom: combinational boot_idx(4) → {addr7, data9}.
- Arbitration and retry logic live in the top module.

## Test plan
- Boot with ideal writer (frm_done/nack = 0 two cycles after each start):
  - frames 340097, 340297, 340479, 340679, 340815, 340A00, 340C00, 340E42, 341019, 341201 in order
  - then boot_done = 1, busy = 0
- Boot index 3 NACKed 4 times with MAX_RETRY = 3:
  - 340679 sent 4 times, err = 1
  - index 4 follows, boot_done still set after index 9
- Index 5 NACKed twice then acked: 340A00 sent 3 times, err stays 0.
- req_a and req_b high together, held, after boot:
  - grants alternate A, B, A, B
  - A addr 7'h04 data 9'h01A → frm_data 34081A
- req_a high during boot: no gnt_a until boot_done. The first idle cycle grants A.
- Reset asserted in S_WAIT of a runtime frame:
  - all outputs 0, late frm_done ignored
  - boot restarts at 340097

Source files
------------

// File: rtl/codec_cfg_sched_pkg.sv
// Shared types, boot table and frame builder for the codec configuration scheduler.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_BOOT_ISSUE,
    S_BOOT_WAIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam int unsigned N_BOOT = 10;

  // Each entry is {addr[6:0], data[8:0]}.
  localparam logic [15:0] BOOT_TABLE [N_BOOT] = '{
    {7'd0, 9'h097}, {7'd1, 9'h097}, {7'd2, 9'h079}, {7'd3, 9'h079}, {7'd4, 9'h015},
    {7'd5, 9'h000}, {7'd6, 9'h000}, {7'd7, 9'h042}, {7'd8, 9'h019}, {7'd9, 9'h001}
  };

  function automatic logic [23:0] build_frame(input logic [7:0] dev,
                                              input logic [6:0] addr,
                                              input logic [8:0] data);
    return {dev, addr, data};
  endfunction

endpackage

// File: rtl/codec_cfg_sched_if.sv
// Requester and I2C frame-writer signals of the codec configuration scheduler.
interface codec_cfg_sched_if;
  logic        req_a;
  logic        req_b;
  logic [6:0]  addr_a;
  logic [6:0]  addr_b;
  logic [8:0]  data_a;
  logic [8:0]  data_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        frm_start;
  logic [23:0] frm_data;
  logic        frm_busy;
  logic        frm_done;
  logic        frm_nack;

  modport slave (
    input  req_a, req_b, addr_a, addr_b, data_a, data_b, frm_busy, frm_done, frm_nack,
    output gnt_a, gnt_b, frm_start, frm_data
  );

  modport master (
    output req_a, req_b, addr_a, addr_b, data_a, data_b, frm_busy, frm_done, frm_nack,
    input  gnt_a, gnt_b, frm_start, frm_data
  );
endinterface

// File: rtl/codec_cfg_sched_boot_rom.sv
// Combinational codec boot table lookup: index -> register address/data.
module codec_boot_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0] boot_idx,
  output logic [6:0] addr,
  output logic [8:0] data
);

  logic [15:0] entry;

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < N_BOOT; i++) begin
      if (boot_idx == 4'(i)) entry = BOOT_TABLE[i];
    end
    addr = entry[15:9];
    data = entry[8:0];
  end

endmodule

// File: rtl/codec_cfg_sched.sv
// Codec configuration scheduler: boot table replay, then round-robin sharing of
// the I2C frame writer between two requesters with bounded NACK retry.
module codec_cfg_sched
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset,
  codec_cfg_sched_if.slave  bus,
  output logic              boot_done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t        state;
  logic [3:0]    boot_idx;
  logic [RW-1:0] retry_cnt;
  logic          last_b;
  logic          grant_a;
  logic [6:0]    rom_addr;
  logic [8:0]    rom_data;

  codec_boot_rom u_boot_rom (
    .boot_idx (boot_idx),
    .addr     (rom_addr),
    .data     (rom_data)
  );

  always_comb begin
    grant_a = bus.req_a && (!bus.req_b || last_b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_BOOT_ISSUE;
      boot_idx      <= '0;
      retry_cnt     <= '0;
      last_b        <= 1'b1;
      boot_done     <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      bus.gnt_a     <= 1'b0;
      bus.gnt_b     <= 1'b0;
      bus.frm_start <= 1'b0;
      bus.frm_data  <= '0;
    end else begin
      bus.gnt_a     <= 1'b0;
      bus.gnt_b     <= 1'b0;
      bus.frm_start <= 1'b0;
      case (state)
        S_BOOT_ISSUE: begin
          busy <= 1'b1;
          if (!bus.frm_busy) begin
            bus.frm_start <= 1'b1;
            bus.frm_data  <= build_frame(DEV_ADDR, rom_addr, rom_data);
            state         <= S_BOOT_WAIT;
          end
        end
        S_ISSUE: begin
          if (!bus.frm_busy) begin
            bus.frm_start <= 1'b1;
            state         <= S_WAIT;
          end
        end
        S_BOOT_WAIT, S_WAIT: begin
          if (bus.frm_done) begin
            if (bus.frm_nack && (retry_cnt < RW'(MAX_RETRY))) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= (state == S_BOOT_WAIT) ? S_BOOT_ISSUE : S_ISSUE;
            end else begin
              // A frame dropped after its last retry advances exactly like a success.
              retry_cnt <= '0;
              if (bus.frm_nack) err <= 1'b1;
              if (state == S_WAIT) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else if (boot_idx == 4'(N_BOOT - 1)) begin
                boot_done <= 1'b1;
                state     <= S_IDLE;
                busy      <= 1'b0;
              end else begin
                boot_idx <= boot_idx + 4'd1;
                state    <= S_BOOT_ISSUE;
              end
            end
          end
        end
        S_IDLE: begin
          if (boot_done && (bus.req_a || bus.req_b)) begin
            busy  <= 1'b1;
            state <= S_ISSUE;
            if (grant_a) begin
              bus.gnt_a    <= 1'b1;
              last_b       <= 1'b0;
              bus.frm_data <= build_frame(DEV_ADDR, bus.addr_a, bus.data_a);
            end else begin
              bus.gnt_b    <= 1'b1;
              last_b       <= 1'b1;
              bus.frm_data <= build_frame(DEV_ADDR, bus.addr_b, bus.data_b);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_sched.sv
// Directed bench for codec_cfg_sched: boot replay, retries, arbitration and reset.
module tb_codec_cfg_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic boot_done, busy, err;

  always #5 clk = ~clk;

  codec_cfg_sched_if bus();

  codec_cfg_sched #(
    .DEV_ADDR  (8'h34),
    .MAX_RETRY (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .boot_done (boot_done),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic        nack;
    logic [23:0] frame;
    logic        err;
  } vec_t;

  vec_t        vec[$];
  logic [23:0] bf[10];
  int checks = 0;
  int errors = 0;
  int s1, s2, s3;
  logic in_boot = 1'b0;
  int boot_gnts = 0;

  always @(negedge clk) begin
    if (in_boot && (bus.gnt_a || bus.gnt_b)) boot_gnts++;
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic n, input logic [23:0] f, input logic e);
    vec_t v;
    v.nack = n;
    v.frame = f;
    v.err = e;
    vec.push_back(v);
  endtask

  // Ideal writer: busy after start, done (with the given nack) two cycles after start.
  task automatic serve(input vec_t v, input string name);
    int n = 0;
    while (!bus.frm_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frm_start) begin
      check({name, "_start_timeout"}, 24'(bus.frm_start), 24'd1);
      return;
    end
    check({name, "_frame"}, bus.frm_data, v.frame);
    bus.frm_busy = 1'b1;
    @(negedge clk);
    check({name, "_start_pulse"}, 24'(bus.frm_start), 24'd0);
    check({name, "_data_stable"}, bus.frm_data, v.frame);
    bus.frm_done = 1'b1;
    bus.frm_nack = v.nack;
    bus.frm_busy = 1'b0;
    @(negedge clk);
    bus.frm_done = 1'b0;
    bus.frm_nack = 1'b0;
    check({name, "_err"}, 24'(err), 24'(v.err));
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input string name);
    int n = 0;
    while (!(bus.gnt_a || bus.gnt_b) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 24'({bus.gnt_a, bus.gnt_b}), 24'(exp));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_frm_start"}, 24'(bus.frm_start), 24'd0);
    check({name, "_frm_data"}, bus.frm_data, 24'd0);
    check({name, "_gnt"}, 24'({bus.gnt_a, bus.gnt_b}), 24'd0);
    check({name, "_boot_done"}, 24'(boot_done), 24'd0);
    check({name, "_busy"}, 24'(busy), 24'd0);
    check({name, "_err"}, 24'(err), 24'd0);
  endtask

  initial begin
    vec_t t;
    int n;
    bus.req_a = 1'b0;  bus.req_b = 1'b0;
    bus.addr_a = '0;   bus.addr_b = '0;
    bus.data_a = '0;   bus.data_b = '0;
    bus.frm_busy = 1'b0; bus.frm_done = 1'b0; bus.frm_nack = 1'b0;

    bf = '{24'h340097, 24'h340297, 24'h340479, 24'h340679, 24'h340815,
           24'h340A00, 24'h340C00, 24'h340E42, 24'h341019, 24'h341201};
    // Boot 1: index 5 NACKed twice then acked.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin add(1'b1, bf[i], 1'b0); add(1'b1, bf[i], 1'b0); end
      add(1'b0, bf[i], 1'b0);
    end
    s1 = vec.size();
    // Boot 2: ideal writer after a mid-frame reset.
    for (int i = 0; i < 10; i++) add(1'b0, bf[i], 1'b0);
    s2 = vec.size();
    // Boot 3: index 3 NACKed on all four attempts and dropped.
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        for (int r = 0; r < 3; r++) add(1'b1, bf[i], 1'b0);
        add(1'b1, bf[i], 1'b1);
      end else begin
        add(1'b0, bf[i], (i > 3) ? 1'b1 : 1'b0);
      end
    end
    s3 = vec.size();

    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < s1; i++) serve(vec[i], $sformatf("boot1_%0d", i));
    check("boot1_done", 24'(boot_done), 24'd1);
    check("boot1_busy", 24'(busy), 24'd0);

    bus.addr_a = 7'h04; bus.data_a = 9'h01A;
    bus.addr_b = 7'h05; bus.data_b = 9'h1FF;
    bus.req_a = 1'b1;   bus.req_b = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_gnt((g % 2 == 0) ? 2'b10 : 2'b01, $sformatf("tie_gnt_%0d", g));
      t.nack = 1'b0;
      t.err = 1'b0;
      t.frame = (g % 2 == 0) ? 24'h34081A : 24'h340BFF;
      serve(t, $sformatf("tie_frm_%0d", g));
    end

    bus.req_b = 1'b0;
    wait_gnt(2'b10, "rst_gnt");
    bus.req_a = 1'b0;
    n = 0;
    while (!bus.frm_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_start", 24'(bus.frm_start), 24'd1);
    bus.frm_busy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    bus.frm_busy = 1'b0;
    bus.frm_done = 1'b1;
    bus.frm_nack = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    bus.frm_done = 1'b0;
    bus.frm_nack = 1'b0;
    check("rst_first_start", 24'(bus.frm_start), 24'd1);
    for (int i = s1; i < s2; i++) serve(vec[i], $sformatf("boot2_%0d", i - s1));
    check("boot2_done", 24'(boot_done), 24'd1);

    reset = 1'b0;
    bus.addr_a = 7'h10; bus.data_a = 9'h0AA;
    bus.req_a = 1'b1;
    in_boot = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = s2; i < s3; i++) serve(vec[i], $sformatf("boot3_%0d", i - s2));
    in_boot = 1'b0;
    check("boot3_no_gnt", 24'(boot_gnts), 24'd0);
    check("boot3_done", 24'(boot_done), 24'd1);
    check("boot3_err", 24'(err), 24'd1);
    wait_gnt(2'b10, "post_boot_gnt");
    t.nack = 1'b0;
    t.err = 1'b1;
    t.frame = 24'h3420AA;
    serve(t, "post_boot_frm");
    bus.req_a = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
